// File: rtl/mux_arb_pkg.sv
// mux_arb_pkg: shared constants, FSM state type and the round-robin pick
// helper for the mux_rr_arbiter block.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int HOLD_W  = 8;
  localparam int CNT_W   = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  // Round-robin search starting after the last owner: ptr+1, ptr+2, ptr+3,
  // then ptr itself. Returns ptr+1 when nothing is requesting (callers only
  // use the result when at least one request bit is set).
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] sel;
    logic             found;
    sel   = ptr + 2'd1;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_mux4_w.sv
// mux4_w: WIDTH-bit combinational 4:1 multiplexer.
// Ports:
//   d  input  4*WIDTH  packed data inputs, input i at d[i*WIDTH +: WIDTH]
//   s  input  2        select
//   f  output WIDTH    selected input
module mux4_w #(
  parameter int WIDTH = 1
) (
  input  logic [4*WIDTH-1:0] d,
  input  logic [1:0]         s,
  output logic [WIDTH-1:0]   f
);

  always_comb begin
    f = d[0 +: WIDTH];
    case (s)
      2'd0: f = d[0*WIDTH +: WIDTH];
      2'd1: f = d[1*WIDTH +: WIDTH];
      2'd2: f = d[2*WIDTH +: WIDTH];
      2'd3: f = d[3*WIDTH +: WIDTH];
      default: f = d[0 +: WIDTH];
    endcase
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter sharing one WIDTH-bit 4:1 mux between
// four requesters, with a valid/ready handshake toward one consumer. An owner
// keeps the grant for at most MAX_HOLD accepted beats while others wait.
//
// Optional feature: define MUX_ARB_CNT_EN to add the beat_cnt port, four
// 16-bit saturating per-requester accepted-beat counters.
//
// Ports:
//   clk       input   1        clock
//   rst_n     input   1        asynchronous active-low reset
//   req       input   4        per-requester request (level)
//   d         input   4*WIDTH  mux data, requester i at d[i*WIDTH +: WIDTH]
//   ready     input   1        downstream accepts f this cycle
//   gnt       output  4        registered one-hot grant, zero when idle
//   s         output  2        registered mux select
//   f         output  WIDTH    selected data (combinational from s, d)
//   valid     output  1        owner is granted and still requesting
//   beat_cnt  output  64       accepted-beat counters (MUX_ARB_CNT_EN only)
//
// state    | meaning
// ---------+---------------------------------------------------------
// ST_IDLE  | no owner, gnt=0; waits for any request
// ST_GRANT | requester s owns the mux; counts accepted beats in hold
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*WIDTH-1:0]  d,
  input  logic                      ready,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [SEL_W-1:0]          s,
  output logic [WIDTH-1:0]          f,
  output logic                      valid
`ifdef MUX_ARB_CNT_EN
  ,
  output logic [NUM_REQ*CNT_W-1:0]  beat_cnt
`endif
);

  localparam logic [HOLD_W:0] MAX_HOLD_C = (HOLD_W+1)'(MAX_HOLD);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]    s_q, s_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;

  logic [SEL_W-1:0]    pick;
  logic [NUM_REQ-1:0]  others;
  logic                accept;
  logic [HOLD_W:0]     hold_inc;
  logic                at_limit;

  assign valid  = (state_q == ST_GRANT) & req[s_q];
  assign accept = valid & ready;
  // In ST_GRANT ptr_q equals s_q, so the pick visits every other requester
  // before coming back to the current owner.
  assign pick     = rr_pick(req, ptr_q);
  assign others   = req & ~gnt_q;
  assign hold_inc = {1'b0, hold_q} + 1'b1;
  assign at_limit = accept & (hold_inc == MAX_HOLD_C);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_GRANT;
          gnt_d   = 4'b0001 << pick;
          s_d     = pick;
          ptr_d   = pick;
          hold_d  = '0;
        end
      end
      ST_GRANT: begin
        if (!req[s_q] || (at_limit && |others)) begin
          hold_d = '0;
          if (|others) begin
            gnt_d = 4'b0001 << pick;
            s_d   = pick;
            ptr_d = pick;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (at_limit) begin
          // Limit reached with nobody waiting: owner keeps the grant.
          hold_d = '0;
        end else if (accept) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      s_q     <= '0;
      ptr_q   <= 2'd3;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt = gnt_q;
  assign s   = s_q;

  mux4_w #(.WIDTH(WIDTH)) u_mux (
    .d (d),
    .s (s_q),
    .f (f)
  );

`ifdef MUX_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic [CNT_W-1:0] cnt_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (accept && (s_q == SEL_W'(i)) && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_comb begin
    beat_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) beat_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;

  localparam int W  = 4;
  localparam int MH = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     req;
  logic [4*W-1:0] d;
  logic           ready;
  logic [3:0]     gnt;
  logic [1:0]     s;
  logic [W-1:0]   f;
  logic           valid;
`ifdef MUX_ARB_CNT_EN
  logic [63:0]    beat_cnt;
`endif

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // reference model: owner index (-1 = idle), last owner, beats in this grant
  int m_own, m_ptr, m_hold, m_s;

  mux_rr_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .d     (d),
    .ready (ready),
    .gnt   (gnt),
    .s     (s),
    .f     (f),
    .valid (valid)
`ifdef MUX_ARB_CNT_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic int m_pick(input logic [3:0] r, input int p);
    for (int k = 1; k <= 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic logic [3:0] m_gnt();
    return (m_own < 0) ? 4'b0000 : 4'(1 << m_own);
  endfunction

  function automatic logic m_valid();
    return (m_own >= 0) && req[m_own];
  endfunction

  function automatic logic [W-1:0] m_f();
    return d[m_s*W +: W];
  endfunction

  task automatic model_reset();
    m_own = -1; m_ptr = 3; m_hold = 0; m_s = 0;
  endtask

  // Apply the arbitration rules for one rising edge with current req/ready.
  task automatic model_step();
    logic [3:0] oth;
    logic       acc;
    if (m_own < 0) begin
      if (req != 0) begin
        m_own = m_pick(req, m_ptr); m_ptr = m_own; m_s = m_own; m_hold = 0;
      end
    end else begin
      oth = req & ~(4'(1 << m_own));
      acc = req[m_own] && ready;
      if (!req[m_own] || (acc && m_hold + 1 == MH && oth != 0)) begin
        m_hold = 0;
        if (oth != 0) begin
          m_own = m_pick(oth, m_ptr); m_ptr = m_own; m_s = m_own;
        end else begin
          m_own = -1;
        end
      end else if (acc) begin
        m_hold = (m_hold + 1) % MH;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic rd);
    req = r; ready = rd; d = 16'($urandom);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = '0; ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; ready = 1'b1; d = 16'hA5C3;
    model_reset();
    #3;
    chk_cnt++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b exp 0000", gnt); else pass_cnt++;
    chk_cnt++; if (s !== 2'd0) $display("FAIL reset_s got %0d exp 0", s); else pass_cnt++;
    chk_cnt++; if (valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", valid); else pass_cnt++;
    chk_cnt++; if (f !== 4'h3) $display("FAIL reset_f got %h exp 3", f); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    drive(4'b0100, 1'b1);
    chk_cnt++; if (valid !== 1'b0) $display("FAIL single_idle_valid got %b exp 0", valid); else pass_cnt++;
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(4'b0100, 1'b1);
      chk_cnt++; if (gnt !== 4'b0100) $display("FAIL single_gnt got %b exp 0100", gnt); else pass_cnt++;
      chk_cnt++; if (s !== 2'd2) $display("FAIL single_s got %0d exp 2", s); else pass_cnt++;
      chk_cnt++; if (valid !== 1'b1) $display("FAIL single_valid got %b exp 1", valid); else pass_cnt++;
      chk_cnt++; if (f !== d[11:8]) $display("FAIL single_f got %h exp %h", f, d[11:8]); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_all_req();
    int own;
    do_reset();
    drive(4'b1111, 1'b1);
    tick();
    for (int k = 1; k <= 20; k++) begin
      drive(4'b1111, 1'b1);
      own = ((k - 1) / MH) % 4;
      chk_cnt++; if (gnt !== 4'(1 << own)) $display("FAIL all_gnt cyc %0d got %b exp %b", k, gnt, 4'(1 << own)); else pass_cnt++;
      chk_cnt++; if (valid !== 1'b1) $display("FAIL all_valid cyc %0d got %b exp 1", k, valid); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_hold_wrap();
    do_reset();
    drive(4'b0010, 1'b1);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(4'b0010, 1'b1);
      chk_cnt++; if (gnt !== 4'b0010) $display("FAIL wrap_gnt cyc %0d got %b exp 0010", k, gnt); else pass_cnt++;
      chk_cnt++; if (valid !== 1'b1) $display("FAIL wrap_valid cyc %0d got %b exp 1", k, valid); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp_g;
    do_reset();
    drive(4'b0001, 1'b1);
    tick();
    for (int k = 0; k < 6; k++) begin
      drive(4'b1001, 1'b0);
      chk_cnt++; if (gnt !== 4'b0001) $display("FAIL stall_gnt cyc %0d got %b exp 0001", k, gnt); else pass_cnt++;
      tick();
    end
    for (int k = 0; k < 5; k++) begin
      drive(4'b1001, 1'b1);
      exp_g = (k < MH) ? 4'b0001 : 4'b1000;
      chk_cnt++; if (gnt !== exp_g) $display("FAIL stall_beat_gnt beat %0d got %b exp %b", k, gnt, exp_g); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(4'b0100, 1'b1);
    tick();
    drive(4'b1111, 1'b1);
    chk_cnt++; if (gnt !== 4'b0100) $display("FAIL mid_pre_gnt got %b exp 0100", gnt); else pass_cnt++;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk_cnt++; if (gnt !== 4'b0000) $display("FAIL mid_gnt got %b exp 0000", gnt); else pass_cnt++;
    chk_cnt++; if (s !== 2'd0) $display("FAIL mid_s got %0d exp 0", s); else pass_cnt++;
    chk_cnt++; if (valid !== 1'b0) $display("FAIL mid_valid got %b exp 0", valid); else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    drive(4'b1111, 1'b1);
    chk_cnt++; if (gnt !== 4'b0001) $display("FAIL mid_after_gnt got %b exp 0001", gnt); else pass_cnt++;
    tick();
  endtask

  task automatic test_random();
    logic [3:0] r;
    do_reset();
    r = 4'($urandom);
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      drive(r, 1'($urandom_range(0, 3) != 0));
      chk_cnt++; if (gnt !== m_gnt()) $display("FAIL rand_gnt cyc %0d got %b exp %b", k, gnt, m_gnt()); else pass_cnt++;
      chk_cnt++; if (s !== 2'(m_s)) $display("FAIL rand_s cyc %0d got %0d exp %0d", k, s, m_s); else pass_cnt++;
      chk_cnt++; if (valid !== m_valid()) $display("FAIL rand_valid cyc %0d got %b exp %b", k, valid, m_valid()); else pass_cnt++;
      chk_cnt++; if (f !== m_f()) $display("FAIL rand_f cyc %0d got %h exp %h", k, f, m_f()); else pass_cnt++;
      tick();
    end
  endtask

`ifdef MUX_ARB_CNT_EN
  task automatic test_counters();
    do_reset();
    drive(4'b1000, 1'b1);
    tick();
    for (int k = 0; k < 5; k++) begin
      drive(4'b1000, 1'b1);
      tick();
    end
    drive(4'b0000, 1'b1);
    chk_cnt++; if (beat_cnt !== {16'd5, 48'd0}) $display("FAIL cnt_five got %h exp %h", beat_cnt, {16'd5, 48'd0}); else pass_cnt++;
    tick();
    req = 4'b1000; ready = 1'b1;
    repeat (65540) tick();
    @(negedge clk);
    chk_cnt++; if (beat_cnt !== {16'hFFFF, 48'd0}) $display("FAIL cnt_sat got %h exp %h", beat_cnt, {16'hFFFF, 48'd0}); else pass_cnt++;
    tick();
  endtask
`endif

  initial begin
    rst_n = 1'b0; req = '0; ready = 1'b0; d = '0;
    model_reset();
    test_reset();
    test_single();
    test_all_req();
    test_hold_wrap();
    test_stall();
    test_reset_mid();
    test_random();
`ifdef MUX_ARB_CNT_EN
    test_counters();
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one WIDTH-bit 4:1 multiplexer between four requesters. It registers a one-hot grant and the matching 2-bit select `s`, then drives the selected input onto `f` with a valid/ready handshake toward the single downstream consumer. The owner keeps the grant for at most MAX_HOLD accepted beats while others wait. It sits directly in front of the combinational mux datapath and replaces hand-driven select stimulus with sequenced arbitration.

## Interface
- WIDTH, 1: bit width of each mux data input and of `f`.
- MAX_HOLD, 4: maximum accepted beats per grant when another requester is waiting; legal range 1..255.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  per-requester request; level-held until the requester has no more beats.
- d  input  4*WIDTH  mux data inputs; requester i owns d[i*WIDTH +: WIDTH].
- ready  input  1  downstream accepts `f` this cycle.
- gnt  output  4  registered one-hot grant; all zeros when idle.
- s  output  2  registered mux select; equals the index of the set `gnt` bit.
- f  output  WIDTH  equals d[s*WIDTH +: WIDTH], combinational from `s` and `d`.
- valid  output  1  asserted when (state==GRANT) & req[s].
- beat_cnt  output  64  present only with MUX_ARB_CNT_EN (see Configuration).

## Operation
- States: IDLE and GRANT. Registers: state, gnt, s, ptr (last owner, 2 bits), hold (8 bits).
- Reset values: state=IDLE, gnt=4'b0000, s=2'b00, ptr=2'd3, hold=0, valid=0. `f` shows d[0] while held in reset.
- Pick function: search order ptr+1, ptr+2, ptr+3, ptr (mod 4); choose the first index with req set.
- IDLE: if any req is set, then at the next edge go to GRANT with gnt=onehot(pick), s=pick, ptr=pick, and hold=0. Otherwise stay in IDLE.
- GRANT, accepted beat: an accepted beat is valid & ready. Each accepted beat increments hold.
- GRANT, release conditions. Release occurs if either of the following holds:
  - req[s]=0, or
  - hold+1==MAX_HOLD on an accepted beat while any other req bit is set.
- GRANT, on release: if any other req is set, the grant moves directly to the pick result at the next edge (GRANT→GRANT, no bubble), with hold=0 and ptr updated. Otherwise go to IDLE and set gnt to 0.
- Hold limit with no contender: when MAX_HOLD is reached and no other req bit is set, the owner keeps the grant and hold wraps to 0.
- ready=0 stalls hold; stalled beats are not counted.
- Simultaneous events:
  - If the owner drops req in the same cycle a new requester rises, the new requester is granted at the next edge.
  - If all four request, service order is 0,1,2,3,0…

## Timing
- Request to grant: 1 cycle from IDLE. `valid` asserts in the cycle after req is sampled.
- Owner switch: 0 idle cycles; the new gnt/s is visible in the cycle after the releasing beat.
- `f` changes in the same cycle as `s`; there are no register stages on the data path.
- Reset asserted mid-grant: outputs return to reset values immediately (asynchronous). The in-flight beat is dropped, and after release ptr=3 again.

## Configuration
- Macro MUX_ARB_CNT_EN.
- Defined: `beat_cnt` port exists as four 16-bit saturating counters. beat_cnt[i*16 +: 16] counts accepted beats of requester i, resets to 0, and holds at 16'hFFFF once reached.
- Undefined: the port and the counter logic are absent, and all other behaviour is identical.

## Structure
- Package mux_arb_pkg: NUM_REQ=4, SEL_W=2, HOLD_W=8, CNT_W=16, and the state enum {ST_IDLE, ST_GRANT}.
- Sub-module mux4_w: parameterised WIDTH combinational 4:1 mux, with ports d, s, f, instantiated once.
- The arbiter FSM, pick function and optional counters live in the top module.

## Test plan
- Reset, then req=4'b0100 with ready=1. Expected: gnt=4'b0100, s=2 and valid=1 one cycle later; `f` tracks d[2].
- req=4'b1111, ready=1, MAX_HOLD=4. Expected: grants in order 0,1,2,3,0, with four valid beats each and no idle cycle between owners.
- Only req[1] held for 10 cycles. Expected: gnt stays 4'b0010 for all 10 beats and hold wraps without a release.
- Owner 0 with ready held low for 6 cycles while req[3]=1. Expected: no hold increment and gnt stays 4'b0001; the grant moves to 3 after 4 accepted beats.
- In GRANT on requester 2, assert rst_n=0 for 2 cycles with all req set. Expected: gnt=0, s=0 and valid=0 immediately; after release the first grant goes to requester 0.
- With MUX_ARB_CNT_EN defined, run 5 accepted beats for requester 3. Expected: beat_cnt[63:48]=5 and all other counters 0. Also force the count to 16'hFFFF and check it saturates.
